onehot_rr_scheduler: RTL and testbench

Sequential round-robin scheduler that sits directly upstream of the 16-to-4 one-hot encoder. It collects single-cycle request pulses from 16 sources into sticky pending bits and issues them one at a time as a registered one-hot grant word, under a valid/ready handshake. The grant word feeds the encoder input unchanged. The matching 4-bit index is also provided for local use.

---
 rtl/onehot_sched_pkg.sv | 26 ++
 rtl/onehot_rr_scheduler_rr_pick.sv | 30 +++
 rtl/onehot_rr_scheduler.sv | 107 ++++++++++
 tb/tb_onehot_rr_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/onehot_sched_pkg.sv
// Purpose: shared constants, FSM state type and one-hot helper for the round-robin scheduler.
// Latency: n/a (declarations and a combinational function only).
// Backpressure: n/a.
package onehot_sched_pkg;

    localparam int N = 16;
    localparam int W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

    // Binary index of the set bit of a one-hot word; 0 for an all-zero word.
    function automatic logic [W-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                idx = idx | i[W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_rr_scheduler_rr_pick.sv
// Purpose: combinational round-robin pick of one bit from a vector, starting at ptr.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module rr_pick
    import onehot_sched_pkg::*;
(
    input  logic [N-1:0] vector,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [2*N-1:0] rot_wide;
    logic [N-1:0]   rot;
    logic [N-1:0]   prio;
    logic [2*N-1:0] unrot_wide;

    // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot_wide   = {vector, vector} >> ptr;
        rot        = rot_wide[N-1:0];
        prio       = rot & (~rot + N'(1));
        unrot_wide = {prio, prio} << ptr;
        onehot     = unrot_wide[2*N-1:N];
        idx        = onehot_to_idx(onehot);
        any        = |vector;
    end

endmodule

// File: rtl/onehot_rr_scheduler.sv
// Purpose: collects request pulses into sticky pending bits and issues one-hot grants in round-robin order.
// Latency: one cycle from a request pulse (in IDLE) to out_valid; back-to-back grants thereafter.
// Backpressure: grant and grant_idx hold stable while out_valid && !out_ready.
module onehot_rr_scheduler
    import onehot_sched_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_set,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         busy
);

    sched_state_e state_q, state_d;
    logic [N-1:0] grant_q, grant_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         xfer;
    logic [N-1:0] clr;
    logic [N-1:0] pick_onehot;
    logic [W-1:0] pick_idx;
    logic         pick_any;

    // Transfer detection, pending update and pointer advance feeding the picker.
    always_comb begin
        xfer      = (state_q == GRANT) && out_ready;
        clr       = xfer ? grant_q : '0;
        // A same-cycle re-request beats the clear, so the source stays pending.
        pending_d = (pending_q & ~clr) | req_set;
        ptr_d     = xfer ? (idx_q + W'(1)) : ptr_q;
    end

    // The pick sees the post-transfer pending vector and the advanced pointer.
    rr_pick u_pick (
        .vector (pending_d),
        .ptr    (ptr_d),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Next-state and grant register logic; grant holds unless issuing a new pick.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = pick_onehot;
                    idx_d   = pick_idx;
                end
            end
            GRANT: begin
                if (xfer) begin
                    if (pick_any) begin
                        grant_d = pick_onehot;
                        idx_d   = pick_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    // State, grant, pending and pointer registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            pending_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
        end
    end

    // Outputs come straight from registers; grant is zero whenever IDLE.
    always_comb begin
        out_valid = (state_q == GRANT);
        grant     = grant_q;
        grant_idx = idx_q;
        pending   = pending_q;
        busy      = out_valid | (|pending_q);
    end

endmodule

// File: tb/tb_onehot_rr_scheduler.sv
module tb_onehot_rr_scheduler;

    logic        clk;
    logic        rst_n;
    logic [15:0] req_set;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] pending;
    logic        busy;

    int errors = 0;
    int checks = 0;

    onehot_rr_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_set   (req_set),
        .grant     (grant),
        .grant_idx (grant_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_set   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant",   32'(grant), 32'h0);
        check("rst_idx",     32'(grant_idx), 32'h0);
        check("rst_valid",   32'(out_valid), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_busy",    32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single request: 1-cycle latency, then transfer and pointer to 5.
        req_set   = 16'h0010;
        out_ready = 1'b1;
        step();
        req_set = '0;
        check("single_valid", 32'(out_valid), 32'h1);
        check("single_grant", 32'(grant), 32'h0010);
        check("single_idx",   32'(grant_idx), 32'h4);
        check("single_busy",  32'(busy), 32'h1);
        step();
        check("single_done_valid", 32'(out_valid), 32'h0);
        check("single_done_pend",  32'(pending), 32'h0);
        check("single_ptr",        32'(dut.ptr_q), 32'h5);

        // Get ptr back to 0 via source 15, then stall test with 0x8001.
        req_set = 16'h8000;
        step();
        req_set = '0;
        check("to_ptr0_grant", 32'(grant), 32'h8000);
        step();
        check("ptr_wrap0", 32'(dut.ptr_q), 32'h0);
        out_ready = 1'b0;
        req_set   = 16'h8001;
        step();
        req_set = '0;
        for (int i = 0; i < 5; i++) begin
            check("stall_grant", 32'(grant), 32'h0001);
            check("stall_valid", 32'(out_valid), 32'h1);
            step();
        end
        check("stall_pending", 32'(pending), 32'h8001);
        out_ready = 1'b1;
        step();
        check("stall_second",  32'(grant), 32'h8000);
        check("stall_second_idx", 32'(grant_idx), 32'hF);
        step();
        check("stall_idle", 32'(out_valid), 32'h0);
        check("stall_busy", 32'(busy), 32'h0);

        // Move ptr to 14 using source 13, then wrap test with 0x4003.
        req_set = 16'h2000;
        step();
        req_set = '0;
        step();
        check("ptr14", 32'(dut.ptr_q), 32'hE);
        out_ready = 1'b0;
        req_set   = 16'h4003;
        step();
        req_set   = '0;
        out_ready = 1'b1;
        check("wrap_g0", 32'(grant), 32'h4000);
        step();
        check("wrap_g1", 32'(grant), 32'h0001);
        step();
        check("wrap_g2", 32'(grant), 32'h0002);
        step();
        check("wrap_idle", 32'(out_valid), 32'h0);

        // Pointer to 0 via source 15, then full fairness sweep.
        req_set = 16'h8000;
        step();
        req_set = '0;
        step();
        out_ready = 1'b0;
        req_set   = 16'hFFFF;
        step();
        req_set   = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("fair_idx", 32'(grant_idx), 32'(k));
            check("fair_grant", 32'(grant), 32'(16'h1 << k));
            if (k == 15) req_set = 16'hFFFF;
            step();
            req_set = '0;
        end
        for (int k = 0; k < 16; k++) begin
            check("fair2_idx", 32'(grant_idx), 32'(k));
            step();
        end
        check("fair_idle", 32'(out_valid), 32'h0);
        check("fair_pend", 32'(pending), 32'h0);

        // Set/clear collision on source 3 with source 5 also pending (ptr=0).
        out_ready = 1'b0;
        req_set   = 16'h0028;
        step();
        req_set = '0;
        check("coll_first", 32'(grant), 32'h0008);
        req_set   = 16'h0008;
        out_ready = 1'b1;
        step();
        req_set = '0;
        check("coll_pending", 32'(pending), 32'h0028);
        check("coll_next",    32'(grant), 32'h0020);
        step();
        check("coll_regrant", 32'(grant), 32'h0008);
        step();
        check("coll_idle",    32'(out_valid), 32'h0);

        // Asynchronous reset between edges while a grant is outstanding.
        out_ready = 1'b0;
        req_set   = 16'h00FF;
        step();
        req_set = '0;
        check("mid_valid",   32'(out_valid), 32'h1);
        check("mid_pending", 32'(pending), 32'h00FF);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",   32'(out_valid), 32'h0);
        check("arst_grant",   32'(grant), 32'h0);
        check("arst_idx",     32'(grant_idx), 32'h0);
        check("arst_pending", 32'(pending), 32'h0);
        check("arst_busy",    32'(busy), 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        check("post_rst_valid", 32'(out_valid), 32'h0);
        check("post_rst_busy",  32'(busy), 32'h0);
        check("post_rst_ptr",   32'(dut.ptr_q), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the bench always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
